// File: rtl/floo_vc_input_buffer.sv
// Per-VC input buffer: one FIFO per virtual channel behind a shared flit bus.
// Ports:
//   clk_i, rst_i (sync, active-high)
//   valid_i/ready_o/data_i : upstream bus, per-VC handshake
//   valid_o/ready_i/data_o : per-VC head flit, first-word fall-through
//   fill_o : per-VC occupancy; hwm_o : per-VC high-water mark
// Optional: FLOO_VC_INPUT_BUFFER_HWM_EN enables hwm_o, else hwm_o is 0.
module floo_vc_input_buffer #(
  parameter int unsigned NumVirtChannels = 2,
  parameter int unsigned Depth = 4,
  parameter type flit_t = logic,
  parameter int unsigned CntWidth = $clog2(Depth + 1)
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic [NumVirtChannels-1:0] valid_i,
  output logic [NumVirtChannels-1:0] ready_o,
  input  flit_t data_i,
  output logic [NumVirtChannels-1:0] valid_o,
  input  logic [NumVirtChannels-1:0] ready_i,
  output flit_t [NumVirtChannels-1:0] data_o,
  output logic [NumVirtChannels-1:0][CntWidth-1:0] fill_o,
  output logic [NumVirtChannels-1:0][CntWidth-1:0] hwm_o
);

  localparam int unsigned PtrWidth =
    (Depth > 1) ? $clog2(Depth) : 1;

  typedef logic [PtrWidth-1:0] ptr_t;
  typedef logic [CntWidth-1:0] cnt_t;

  localparam cnt_t DepthCnt = cnt_t'(Depth);
  localparam ptr_t LastPtr = ptr_t'(Depth - 1);

  flit_t [Depth-1:0] mem_q [NumVirtChannels];
  ptr_t [NumVirtChannels-1:0] wptr_q;
  ptr_t [NumVirtChannels-1:0] rptr_q;
  cnt_t [NumVirtChannels-1:0] cnt_q;
  cnt_t [NumVirtChannels-1:0] cnt_d;
  logic [NumVirtChannels-1:0] push;
  logic [NumVirtChannels-1:0] pop;

  // Depth need not be a power of two, so wrap explicitly.
  function automatic ptr_t nxt(input ptr_t p);
    return (p == LastPtr) ? '0 : p + ptr_t'(1);
  endfunction

  // ready_o looks only at local state: no ready_i -> ready_o path,
  // and a full FIFO refuses even when it is popped this cycle.
  always_comb begin
    ready_o = '0;
    valid_o = '0;
    push = '0;
    pop = '0;
    cnt_d = cnt_q;
    data_o = '0;
    for (int v = 0; v < NumVirtChannels; v++) begin
      ready_o[v] = !rst_i && (cnt_q[v] != DepthCnt);
      valid_o[v] = !rst_i && (cnt_q[v] != '0);
      data_o[v] = mem_q[v][rptr_q[v]];
      push[v] = valid_i[v] && ready_o[v];
      pop[v] = valid_o[v] && ready_i[v];
      unique case (1'b1)
        push[v] && !pop[v]: cnt_d[v] = cnt_q[v] + cnt_t'(1);
        pop[v] && !push[v]: cnt_d[v] = cnt_q[v] - cnt_t'(1);
        default: cnt_d[v] = cnt_q[v];
      endcase
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wptr_q <= '0;
      rptr_q <= '0;
      cnt_q <= '0;
    end else begin
      for (int v = 0; v < NumVirtChannels; v++) begin
        if (push[v]) wptr_q[v] <= nxt(wptr_q[v]);
        if (pop[v]) rptr_q[v] <= nxt(rptr_q[v]);
      end
      cnt_q <= cnt_d;
    end
  end

  // Storage is not reset; stale entries are unreachable once counts clear.
  always_ff @(posedge clk_i) begin
    for (int v = 0; v < NumVirtChannels; v++) begin
      if (push[v]) mem_q[v][wptr_q[v]] <= data_i;
    end
  end

  assign fill_o = cnt_q;

`ifdef FLOO_VC_INPUT_BUFFER_HWM_EN
  cnt_t [NumVirtChannels-1:0] hwm_q;

  // Tracks the registered count, so it trails fill_o by one cycle.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      hwm_q <= '0;
    end else begin
      for (int v = 0; v < NumVirtChannels; v++) begin
        if (cnt_q[v] > hwm_q[v]) hwm_q[v] <= cnt_q[v];
      end
    end
  end

  assign hwm_o = hwm_q;
`else
  assign hwm_o = '0;
`endif

`ifndef SYNTHESIS
  a_one_push: assert property (
    @(posedge clk_i) disable iff (rst_i)
    $onehot0(valid_i & ready_o)
  );
`endif

endmodule
